mm_mac_param: RTL
=================

Name: mm_mac_param

Overview:
- Parametrised successor to the fixed 8x8 matrix-multiply MAC controller. Computes C = A x B for signed NxN matrices of DW-bit elements using one shared multiply-accumulate datapath.
- A and B are loaded through a write port instead of file init. C is read through a registered read port.
- start/busy/done handshake plus a cycle counter. Sits between the host/testbench loader and downstream result consumers.

Parameters:
- N, 8, matrix dimension (N >= 2, power of two).
- DW, 8, signed element width of A and B.
- AW, 2*DW+$clog2(N), signed accumulator/result width (19 at defaults).
- CW, $clog2(N*N*N+1), clk_count width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a multiply; sampled only in IDLE or DONE.
- ld_en  in  1  write one element into A or B.
- ld_sel  in  1  0 = A, 1 = B.
- ld_addr  in  $clog2(N*N)  row-major index, i*N + k.
- ld_data  in  DW  signed element.
- rd_addr  in  $clog2(N*N)  C index, row-major.
- rd_data  out  AW  C[rd_addr], registered.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- ld_err  out  1  one-cycle pulse when ld_en is rejected.
- clk_count  out  CW  cycles spent in RUN for the current or last job.

Behaviour:
- **Reset (reset=0, async):**
  - State goes to IDLE.
  - busy=0, done=0, ld_err=0, clk_count=0, rd_data=0, indices i/j/k=0, acc=0.
  - A/B/C arrays are not cleared.
- **States:** IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN next edge; clk_count and i/j/k cleared on the same edge.
  - RUN: one product per cycle. Loop order is j outer, i middle, k inner, so C is produced column by column.
    - Each cycle: p = A[i*N+k] * B[k*N+j], signed, full 2*DW, sign-extended to AW.
    - k==0: acc <= p.
    - 0<k<N-1: acc <= acc + p.
    - k==N-1: C[i*N+j] <= acc + p; k wraps to 0 and i increments. When i wraps, j increments.
    - clk_count increments every RUN cycle.
    - After the product with i=j=k=N-1 is written: -> DONE. Total RUN time is exactly N^3 cycles (512 at defaults). The final clk_count equals N^3.
  - DONE: done=1 and busy=0, held. start=1 -> RUN (done drops the same edge; counters cleared). Otherwise stay.
- **Loading:** ld_en is accepted in IDLE or DONE and writes the selected array at the next edge. ld_en during RUN is ignored and ld_err pulses for 1 cycle.
- **Reading:** rd_data <= C[rd_addr] every cycle (1-cycle latency), in all states. During RUN, entries not yet rewritten return their prior values.
- **Ignored/illegal inputs:**
  - start during RUN is ignored.
  - start and ld_en together in IDLE: the load is performed, then RUN starts. The load takes effect before the first product.
  - Out-of-range addresses cannot occur, since N is a power of two.
- **Arithmetic:**
  - Two's complement, no saturation.
  - AW guarantees no overflow for a single product sum.
  - With the accumulate feature on, overflow wraps modulo 2^AW.
- **Reset mid-RUN:** aborts immediately to IDLE. Partially written C entries remain. The next start recomputes all entries.

Optional Feature:
- Macro MM_MAC_ACCUM_EN.
  - Defined: at k==0, acc <= C[i*N+j] + p instead of p, so a job computes C = C + A x B. A new input clr_c (1 bit, sampled in IDLE/DONE) zeroes all of C in one cycle.
  - Undefined: C is overwritten each job and the clr_c port does not exist.
- Cycle counts are identical in both builds.

Decomposition:
- Package mm_mac_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - ld_sel constants (SEL_A=0, SEL_B=1);
  - width helper functions (acc width from DW and N).
- One sub-module, mm_mac_unit. It holds the signed DW x DW multiplier plus the AW-wide accumulator, with inputs first (load vs accumulate select) and en. The controller, arrays and counters stay in mm_mac_param.

Test Plan:
- A = identity, B[r][c] = r*N+c, start -> done after exactly 512 RUN cycles; clk_count=512; every C equals B.
- All A = B = -128 -> every C = 131072 (fits 19-bit signed); all A=127, B=-128 -> every C = -130048.
- Load during RUN -> ld_err pulses, A unchanged; start during RUN -> no restart; clk_count still ends at 512.
- Assert reset low at RUN cycle 200 -> busy=0, done=0, clk_count=0 asynchronously; new start -> full correct result in 512 cycles.
- Read C[0], C[63] back-to-back -> each valid 1 cycle after rd_addr; done held until next start.
- MM_MAC_ACCUM_EN: clr_c, run A=I, B=all 3 twice -> all C = 6; without macro, same sequence -> all C = 3.

Source files
------------

// File: rtl/mm_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mm_mac_pkg
// Purpose : Shared state encoding, load-select constants and width helpers
//           for the parametrised matrix-multiply MAC.
// Revision: 1.0 - initial parametrised release
// ============================================================================
package mm_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Full product width plus headroom for summing N products.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_mac_unit.sv
`default_nettype none
// ============================================================================
// Module  : mm_mac_unit
// Purpose : Signed DW x DW multiplier feeding an AW-wide accumulator.
//           'first' restarts the sum from 'base', otherwise adds to acc.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module mm_mac_unit #(
    parameter int DW = 8,
    parameter int AW = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 first,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic signed [AW-1:0] base,
    output logic signed [AW-1:0] sum
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_prod_ext;
    logic signed [AW-1:0]   r_acc;

    assign w_prod     = a * b;
    assign w_prod_ext = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign sum        = (first ? base : r_acc) + w_prod_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_mac_param.sv
`default_nettype none
// ============================================================================
// Module  : mm_mac_param
// Purpose : C = A x B for signed NxN matrices on one shared MAC, with load
//           port, registered read port, start/busy/done and cycle counter.
//           Optional MM_MAC_ACCUM_EN: C = C + A x B plus a clr_c input.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module mm_mac_param
    import mm_mac_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = acc_width(DW, N),
    parameter int CW = $clog2(N*N*N+1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
`ifdef MM_MAC_ACCUM_EN
    input  logic                       clr_c,
`endif
    input  logic                       ld_en,
    input  logic                       ld_sel,
    input  logic [$clog2(N*N)-1:0]     ld_addr,
    input  logic signed [DW-1:0]       ld_data,
    input  logic [$clog2(N*N)-1:0]     rd_addr,
    output logic signed [AW-1:0]       rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       ld_err,
    output logic [CW-1:0]              clk_count
);

    localparam int              c_IW  = $clog2(N);
    localparam int              c_LAW = 2 * c_IW;
    localparam logic [c_IW-1:0] c_MAX = c_IW'(N-1);

    state_t r_state;
    state_t w_state_nxt;

    logic [c_IW-1:0] r_i;
    logic [c_IW-1:0] r_j;
    logic [c_IW-1:0] r_k;
    logic [CW-1:0]   r_count;
    logic            r_ld_err;
    logic signed [AW-1:0] r_rd_data;

    logic signed [DW-1:0] r_a [N*N];
    logic signed [DW-1:0] r_b [N*N];
    logic signed [AW-1:0] r_c [N*N];

    logic w_busy;
    logic w_done;
    logic w_ld_ok;
    logic w_launch;
    logic w_k_last;
    logic w_i_last;
    logic w_j_last;
    logic w_run;

    logic [c_LAW-1:0]     w_a_idx;
    logic [c_LAW-1:0]     w_b_idx;
    logic [c_LAW-1:0]     w_c_idx;
    logic signed [AW-1:0] w_base;
    logic signed [AW-1:0] w_sum;

    // Power-of-two N lets row-major indices be plain concatenations.
    assign w_a_idx  = {r_i, r_k};
    assign w_b_idx  = {r_k, r_j};
    assign w_c_idx  = {r_i, r_j};
    assign w_k_last = (r_k == c_MAX);
    assign w_i_last = (r_i == c_MAX);
    assign w_j_last = (r_j == c_MAX);
    assign w_run    = (r_state == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_ld_ok     = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_done  = (r_state == ST_DONE);
                w_ld_ok = ld_en;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_launch    = 1'b1;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_k_last && w_i_last && w_j_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_count   <= '0;
            r_ld_err  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_ld_err  <= w_run && ld_en;
            r_rd_data <= r_c[rd_addr];
            if (w_launch) begin
                r_i     <= '0;
                r_j     <= '0;
                r_k     <= '0;
                r_count <= '0;
            end else if (w_run) begin
                // j outer, i middle, k inner: C fills column by column.
                r_count <= r_count + 1'b1;
                r_k     <= r_k + 1'b1;
                if (w_k_last) begin
                    r_i <= r_i + 1'b1;
                    if (w_i_last) begin
                        r_j <= r_j + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            if (ld_sel == SEL_B) begin
                r_b[ld_addr] <= ld_data;
            end else begin
                r_a[ld_addr] <= ld_data;
            end
        end
    end

`ifdef MM_MAC_ACCUM_EN
    assign w_base = r_c[w_c_idx];

    always_ff @(posedge clk) begin
        if (clr_c && !w_run) begin
            for (int n = 0; n < N*N; n++) begin
                r_c[n] <= '0;
            end
        end else if (w_run && w_k_last) begin
            r_c[w_c_idx] <= w_sum;
        end
    end
`else
    assign w_base = '0;

    always_ff @(posedge clk) begin
        if (w_run && w_k_last) begin
            r_c[w_c_idx] <= w_sum;
        end
    end
`endif

    mm_mac_unit #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (w_run),
        .first (r_k == '0),
        .a     (r_a[w_a_idx]),
        .b     (r_b[w_b_idx]),
        .base  (w_base),
        .sum   (w_sum)
    );

    assign rd_data   = r_rd_data;
    assign busy      = w_busy;
    assign done      = w_done;
    assign ld_err    = r_ld_err;
    assign clk_count = r_count;

endmodule
`default_nettype wire
